// File: rtl/dmem_pkg.sv
// Shared constants, FSM encoding and request struct for the data-memory responder.
package dmem_pkg;
  localparam int NUM_LANES  = 4;
  localparam int VEC_W      = 8;
  localparam int LANE_SEL_W = $clog2(NUM_LANES);

  localparam logic [2:0] DMEM_SZ_B = 3'b001;
  localparam logic [2:0] DMEM_SZ_H = 3'b010;
  localparam logic [2:0] DMEM_SZ_W = 3'b100;
  localparam int         DMEM_UNS_BIT = 3;

  typedef enum logic {IDLE = 1'b0, MERGE = 1'b1} dmem_state_e;

  typedef struct packed {
    logic [LANE_SEL_W-1:0]      lane;
    logic [2:0]                 size;
    logic [NUM_LANES*VEC_W-1:0] wdata;
  } dmem_st_req_t;

  // Anything that is not a clean byte/half one-hot behaves as a word access.
  function automatic logic [2:0] dmem_norm_size(input logic [2:0] sz);
    case (sz)
      DMEM_SZ_B, DMEM_SZ_H: return sz;
      default:              return DMEM_SZ_W;
    endcase
  endfunction
endpackage

// File: rtl/dmem_lane_fmt.sv
// Combinational lane formatting: load extract with sign/zero extension and sub-word store merge.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [NUM_LANES-1:0][VEC_W-1:0] ld_word,
  input  logic [LANE_SEL_W-1:0]           ld_lane,
  input  logic [2:0]                      ld_size,
  input  logic                            ld_uns,
  output logic [NUM_LANES*VEC_W-1:0]      ld_data,
  input  logic [NUM_LANES-1:0][VEC_W-1:0] st_word,
  input  logic [LANE_SEL_W-1:0]           st_lane,
  input  logic [2:0]                      st_size,
  input  logic [NUM_LANES*VEC_W-1:0]      st_data,
  output logic [NUM_LANES-1:0][VEC_W-1:0] st_merged
);
  localparam int WORD_W = NUM_LANES * VEC_W;

  logic [VEC_W-1:0]   ld_b;
  logic [2*VEC_W-1:0] ld_h;

  assign ld_b = ld_word[ld_lane];
  assign ld_h = ld_lane[1] ? ld_word[3:2] : ld_word[1:0];

  always_comb begin
    ld_data = ld_word;
    if (ld_size == DMEM_SZ_B)
      ld_data = {{(WORD_W-VEC_W){~ld_uns & ld_b[VEC_W-1]}}, ld_b};
    else if (ld_size == DMEM_SZ_H)
      ld_data = {{(WORD_W-2*VEC_W){~ld_uns & ld_h[2*VEC_W-1]}}, ld_h};
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam logic [LANE_SEL_W-1:0] LN = LANE_SEL_W'(i);
    logic             en;
    logic [VEC_W-1:0] src;
    // Sub-word store data sits in the low byte/half and is replicated onto the target lanes.
    assign en  = (st_size == DMEM_SZ_B) ? (st_lane == LN) :
                 (st_size == DMEM_SZ_H) ? (st_lane[1] == LN[1]) : 1'b1;
    assign src = (st_size == DMEM_SZ_W)        ? st_data[i*VEC_W +: VEC_W] :
                 (st_size == DMEM_SZ_H && LN[0]) ? st_data[2*VEC_W-1:VEC_W] :
                                                   st_data[VEC_W-1:0];
    assign st_merged[i] = en ? src : st_word[i];
  end
endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: 1-cycle loads, word stores in place, sub-word stores as 2-cycle RMW.
// Optional DMEM_ERR_EN adds fault_o and rejects misaligned / out-of-range accesses.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 'h0000_1000
)(
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  input  logic                  w_ena_i,
  input  logic                  r_ena_i,
  input  logic [3:0]            sign_mask_i,
  output logic [31:0]           rdata_o,
  output logic                  stall_o
`ifdef DMEM_ERR_EN
  ,
  output logic                  fault_o
`endif
);
  localparam int IDX_W  = $clog2(DEPTH_WORDS);
  localparam int WORD_W = NUM_LANES * VEC_W;

  dmem_state_e              state;
  logic [WORD_W-1:0]        mem [DEPTH_WORDS];
  logic [ADDR_WIDTH-1:0]    offs;
  logic [IDX_W-1:0]         idx, m_idx;
  logic [LANE_SEL_W-1:0]    lane;
  logic [2:0]               size;
  logic                     uns, req, illegal, fault_q;
  logic [WORD_W-1:0]        rd_word, ld_data, m_word, merged;
  dmem_st_req_t             m_req;

  assign offs    = addr_i - BASE_ADDR;
  assign idx     = offs[IDX_W+1:2];
  assign lane    = addr_i[LANE_SEL_W-1:0];
  assign size    = dmem_norm_size(sign_mask_i[2:0]);
  assign uns     = sign_mask_i[DMEM_UNS_BIT];
  assign req     = w_ena_i | r_ena_i;
  assign rd_word = mem[idx];

`ifdef DMEM_ERR_EN
  logic misaligned, out_of_range, unused_offs;
  assign misaligned   = (size == DMEM_SZ_H && addr_i[0]) ||
                        (size == DMEM_SZ_W && addr_i[1:0] != 2'b00);
  assign out_of_range = |offs[ADDR_WIDTH-1:IDX_W+2];
  assign illegal      = misaligned | out_of_range;
  assign fault_o      = fault_q;
  assign unused_offs  = ^offs[1:0];
`else
  logic unused_bits;
  assign illegal     = 1'b0;
  assign unused_bits = ^{offs[ADDR_WIDTH-1:IDX_W+2], offs[1:0], fault_q};
`endif

  dmem_lane_fmt u_fmt (
    .ld_word   (rd_word),
    .ld_lane   (lane),
    .ld_size   (size),
    .ld_uns    (uns),
    .ld_data   (ld_data),
    .st_word   (m_word),
    .st_lane   (m_req.lane),
    .st_size   (m_req.size),
    .st_data   (m_req.wdata),
    .st_merged (merged)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state   <= IDLE;
      stall_o <= 1'b0;
      rdata_o <= '0;
      fault_q <= 1'b0;
    end else begin
      fault_q <= 1'b0;
      case (state)
        IDLE: if (req) begin
          if (illegal) begin
            rdata_o <= '0;
            fault_q <= 1'b1;
          end else begin
            // rd_word is the pre-write contents, so a combined load+store returns the old word.
            if (r_ena_i) rdata_o <= ld_data;
            if (w_ena_i && size == DMEM_SZ_W) begin
              mem[idx] <= wdata_i;
            end else if (w_ena_i) begin
              m_idx   <= idx;
              m_word  <= rd_word;
              m_req   <= '{lane: lane, size: size, wdata: wdata_i};
              state   <= MERGE;
              stall_o <= 1'b1;
            end
          end
        end
        MERGE: begin
          mem[m_idx] <= merged;
          state      <= IDLE;
          stall_o    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder against a byte-addressed reference memory.
module tb_data_mem_responder;
  localparam int          AW    = 32;
  localparam int          DEPTH = 1024;
  localparam int          NB    = 4 * DEPTH;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wdata, rdata;
  logic        w_ena, r_ena, stall;
  logic [3:0]  mask;
`ifdef DMEM_ERR_EN
  logic        fault;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  byte unsigned mb [NB];
  logic [31:0] exp_rdata;

  data_mem_responder #(.ADDR_WIDTH(AW), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .w_ena_i     (w_ena),
    .r_ena_i     (r_ena),
    .sign_mask_i (mask),
    .rdata_o     (rdata),
    .stall_o     (stall)
`ifdef DMEM_ERR_EN
    ,
    .fault_o     (fault)
`endif
  );

  always #5 clk = ~clk;

  function automatic int size_of(input logic [3:0] m);
    case (m[2:0])
      3'b001:  return 1;
      3'b010:  return 2;
      default: return 4;
    endcase
  endfunction

  // Byte offset of the first accessed byte: wrapped into the RAM, rounded down to the access size.
  function automatic int base_of(input logic [31:0] a, input int sz);
    int o;
    o = int'((a - BASE) % NB);
    return (o / sz) * sz;
  endfunction

  function automatic bit is_illegal(input logic [31:0] a, input logic [3:0] m);
`ifdef DMEM_ERR_EN
    int sz;
    sz = size_of(m);
    return ((a % sz) != 0) || ((a - BASE) >= NB);
`else
    return (a === 32'hx) && (m === 4'hx);
`endif
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [3:0] m);
    int sz, b;
    logic [31:0] v;
    sz = size_of(m);
    b  = base_of(a, sz);
    v  = 0;
    for (int k = 0; k < sz; k++) v += 32'(mb[b+k]) << (8*k);
    if (sz < 4 && !m[3] && v[8*sz-1]) v -= (32'd1 << (8*sz));
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    int sz, b;
    sz = size_of(m);
    b  = base_of(a, sz);
    for (int k = 0; k < sz; k++) mb[b+k] = 8'(d >> (8*k));
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input bit w, input bit r,
                       input logic [3:0] m, input string nm);
    bit ill, merge;
    ill   = (w || r) && is_illegal(a, m);
    merge = w && !ill && size_of(m) < 4;
    addr = a; wdata = d; w_ena = w; r_ena = r; mask = m;
    if (w || r) begin
      if (ill) exp_rdata = 0;
      else begin
        if (r) exp_rdata = model_load(a, m);
        if (w) model_store(a, d, m);
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (rdata !== exp_rdata) begin
      n_err++; $display("FAIL %s rdata: got %h want %h (addr %h mask %b)", nm, rdata, exp_rdata, a, m);
    end
    n_cmp++;
    if (stall !== merge) begin
      n_err++; $display("FAIL %s stall: got %b want %b", nm, stall, merge);
    end
`ifdef DMEM_ERR_EN
    n_cmp++;
    if (fault !== ill) begin
      n_err++; $display("FAIL %s fault: got %b want %b", nm, fault, ill);
    end
`endif
    w_ena = 0; r_ena = 0;
    if (merge) begin
      @(posedge clk); #1;
      n_cmp++;
      if (stall !== 1'b0) begin
        n_err++; $display("FAIL %s stall_release: got %b want 0", nm, stall);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1; addr = 0; wdata = 0; w_ena = 0; r_ena = 0; mask = 0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    n_cmp++;
    if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall); end
`ifdef DMEM_ERR_EN
    n_cmp++;
    if (fault !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %b want 0", fault); end
`endif
    reset = 0;
    exp_rdata = 0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) issue(BASE + 32'(4*i), $urandom, 1, 0, 4'b0100, "fill");
  endtask

  task automatic test_word_store_load();
    issue(32'h1000, 32'hDEADBEEF, 1, 0, 4'b0100, "word_store");
    issue(32'h1000, 32'h0, 0, 1, 4'b0100, "word_load");
    n_cmp++;
    if (rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL word_const: got %h want DEADBEEF", rdata); end
  endtask

  task automatic test_subword();
    logic [31:0] prev;
    issue(32'h1001, 32'h80, 1, 0, 4'b0001, "byte_store");
    issue(32'h1000, 32'h0, 0, 1, 4'b0100, "byte_merge_word");
    n_cmp++;
    if (rdata !== 32'hDEAD80EF) begin n_err++; $display("FAIL byte_merge_const: got %h want DEAD80EF", rdata); end
    issue(32'h1001, 32'h0, 0, 1, 4'b0001, "byte_signed");
    n_cmp++;
    if (rdata !== 32'hFFFFFF80) begin n_err++; $display("FAIL byte_signed_const: got %h want FFFFFF80", rdata); end
    issue(32'h1001, 32'h0, 0, 1, 4'b1001, "byte_unsigned");
    n_cmp++;
    if (rdata !== 32'h00000080) begin n_err++; $display("FAIL byte_unsigned_const: got %h want 00000080", rdata); end
    prev = model_load(32'h1004, 4'b0100);
    issue(32'h1006, 32'h1234, 1, 0, 4'b0010, "half_store");
    issue(32'h1006, 32'h0, 0, 1, 4'b0010, "half_signed");
    n_cmp++;
    if (rdata !== 32'h00001234) begin n_err++; $display("FAIL half_const: got %h want 00001234", rdata); end
    issue(32'h1004, 32'h0, 0, 1, 4'b0100, "half_word");
    n_cmp++;
    if (rdata !== {16'h1234, prev[15:0]}) begin
      n_err++; $display("FAIL half_word_const: got %h want %h", rdata, {16'h1234, prev[15:0]});
    end
  endtask

  task automatic test_reset_in_merge();
    logic [31:0] pre;
    pre = model_load(32'h1010, 4'b0100);
    addr = 32'h1011; wdata = 32'hAB; w_ena = 1; r_ena = 0; mask = 4'b0001;
    @(posedge clk); #1;
    n_cmp++;
    if (stall !== 1'b1) begin n_err++; $display("FAIL merge_entry_stall: got %b want 1", stall); end
    w_ena = 0; reset = 1;
    @(posedge clk); #1;
    reset = 0;
    exp_rdata = 0;
    n_cmp++;
    if (stall !== 1'b0) begin n_err++; $display("FAIL merge_reset_stall: got %b want 0", stall); end
    n_cmp++;
    if (rdata !== 32'h0) begin n_err++; $display("FAIL merge_reset_rdata: got %h want 0", rdata); end
    issue(32'h1010, 32'h0, 0, 1, 4'b0100, "merge_abort_load");
    n_cmp++;
    if (rdata !== pre) begin n_err++; $display("FAIL merge_abort_const: got %h want %h", rdata, pre); end
  endtask

  task automatic test_back_to_back();
    issue(32'h1020, 32'h22222222, 1, 0, 4'b0100, "rw_prep");
    issue(32'h1020, 32'h11111111, 1, 1, 4'b0100, "rw_both");
    n_cmp++;
    if (rdata !== 32'h22222222) begin n_err++; $display("FAIL rw_old_const: got %h want 22222222", rdata); end
    issue(32'h1020, 32'h0, 0, 1, 4'b0100, "rw_new");
    n_cmp++;
    if (rdata !== 32'h11111111) begin n_err++; $display("FAIL rw_new_const: got %h want 11111111", rdata); end
    for (int i = 0; i < 8; i++) issue(BASE + 32'($urandom_range(0, NB-1)), 0, 0, 1, 4'($urandom), "b2b_load");
    issue(32'h0, 32'h0, 0, 0, 4'b0000, "hold");
  endtask

`ifdef DMEM_ERR_EN
  task automatic test_fault();
    logic [31:0] pre;
    issue(32'h1003, 32'h0, 0, 1, 4'b0010, "fault_half");
    issue(32'h0, 32'h0, 0, 0, 4'b0000, "fault_pulse_end");
    pre = model_load(32'h1FFC, 4'b0100);
    issue(32'h0FFC, 32'hCAFEF00D, 1, 0, 4'b0100, "fault_store");
    issue(32'h1FFC, 32'h0, 0, 1, 4'b0100, "fault_no_write");
    n_cmp++;
    if (rdata !== pre) begin n_err++; $display("FAIL fault_no_write_const: got %h want %h", rdata, pre); end
  endtask
`endif

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 600; i++) begin
      a = ($urandom_range(0, 7) == 0) ? $urandom : BASE + 32'($urandom_range(0, NB-1));
      issue(a, $urandom, 1'($urandom), 1'($urandom), 4'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_word_store_load();
    test_subword();
    test_reset_in_merge();
    test_back_to_back();
`ifdef DMEM_ERR_EN
    test_fault();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
